cpu_run_controller: RTL and testbench

//  Run/halt/single-step/breakpoint sequencer for the single-cycle CPU datapath. It gates the per-cycle

---
 rtl/cpu_ctrl_pkg.sv | 22 ++
 rtl/cpu_run_controller_counter.sv | 28 ++
 rtl/cpu_run_controller.sv | 116 +++++++++++
 tb/tb_cpu_run_controller.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared types and defaults for the CPU run controller.
// State encoding, default widths and counter limit.
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_HALTED = 2'd1,
        ST_RUN    = 2'd2,
        ST_STEP   = 2'd3
    } run_state_t;

    localparam int DEF_PC_WIDTH    = 8;
    localparam int DEF_COUNT_WIDTH = 16;

    localparam logic [DEF_COUNT_WIDTH-1:0] COUNT_MAX = '1;

    // Width of the power-up hold counter for a given hold length.
    function automatic int hold_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/cpu_run_controller_counter.sv
// Retired-instruction counter with sticky wrap flag.
// Synchronous active-low clear.
module instruction_counter
    import cpu_ctrl_pkg::*;
#(
    parameter int COUNT_WIDTH = DEF_COUNT_WIDTH
) (
    input  logic                   clock,
    input  logic                   clear_n,
    input  logic                   enable,
    output logic [COUNT_WIDTH-1:0] count,
    output logic                   overflow
);

    // Count retirements; flag the wrap from all-ones back to zero.
    always_ff @(posedge clock) begin
        if (!clear_n) begin
            count    <= '0;
            overflow <= 1'b0;
        end else if (enable) begin
            count <= count + COUNT_WIDTH'(1);
            if (&count) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cpu_run_controller.sv
// Run/halt/step/breakpoint sequencer for the CPU datapath.
// cpuEnable gates PC update and register write-back.
module cpu_run_controller
    import cpu_ctrl_pkg::*;
#(
    parameter int PC_WIDTH     = DEF_PC_WIDTH,
    parameter int COUNT_WIDTH  = DEF_COUNT_WIDTH,
    parameter int RESET_CYCLES = 4,
    parameter bit START_HALTED = 1'b1
) (
    input  logic                   clock,
    input  logic                   isResetN,
    input  logic                   runRequest,
    input  logic                   haltRequest,
    input  logic                   stepRequest,
    input  logic                   haltInstruction,
    input  logic                   breakEnable,
    input  logic [PC_WIDTH-1:0]    breakAddress,
    input  logic [PC_WIDTH-1:0]    pc,
    output logic                   cpuEnable,
    output logic                   cpuReset,
    output logic                   halted,
    output logic                   breakHit,
    output logic                   stepDone,
    output logic [COUNT_WIDTH-1:0] instructionCount,
    output logic                   countOverflow
);

    localparam int HOLD_W = hold_width(RESET_CYCLES);

    run_state_t        state;
    logic [HOLD_W-1:0] hold_count;
    logic              skip_break;
    logic              bp_match;

    // A breakpoint only traps in RUN, and not on the resume cycle.
    assign bp_match = (state == ST_RUN) & breakEnable
                    & (pc == breakAddress) & ~skip_break;

    // Retire on the single STEP cycle or any untrapped RUN cycle.
    assign cpuEnable = (state == ST_STEP)
                     | ((state == ST_RUN) & ~bp_match);

    // Sequencer state and registered status outputs.
    always_ff @(posedge clock) begin
        if (!isResetN) begin
            state      <= ST_RESET;
            hold_count <= '0;
            cpuReset   <= 1'b1;
            halted     <= 1'b0;
            breakHit   <= 1'b0;
            stepDone   <= 1'b0;
            skip_break <= 1'b0;
        end else begin
            stepDone <= 1'b0;
            unique case (state)
                ST_RESET: begin
                    hold_count <= hold_count + HOLD_W'(1);
                    if (hold_count == HOLD_W'(RESET_CYCLES - 1)) begin
                        cpuReset <= 1'b0;
                        if (START_HALTED) begin
                            state  <= ST_HALTED;
                            halted <= 1'b1;
                        end else begin
                            state  <= ST_RUN;
                        end
                    end
                end
                ST_HALTED: begin
                    if (haltRequest) begin
                        state <= ST_HALTED;
                    end else if (stepRequest) begin
                        state    <= ST_STEP;
                        halted   <= 1'b0;
                        breakHit <= 1'b0;
                    end else if (runRequest) begin
                        state      <= ST_RUN;
                        halted     <= 1'b0;
                        breakHit   <= 1'b0;
                        skip_break <= 1'b1;
                    end
                end
                ST_STEP: begin
                    state    <= ST_HALTED;
                    halted   <= 1'b1;
                    stepDone <= 1'b1;
                end
                ST_RUN: begin
                    skip_break <= 1'b0;
                    if (bp_match) begin
                        state    <= ST_HALTED;
                        halted   <= 1'b1;
                        breakHit <= 1'b1;
                    end else if (haltRequest | haltInstruction) begin
                        state  <= ST_HALTED;
                        halted <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_RESET;
                end
            endcase
        end
    end

    instruction_counter #(
        .COUNT_WIDTH (COUNT_WIDTH)
    ) u_counter (
        .clock    (clock),
        .clear_n  (isResetN),
        .enable   (cpuEnable),
        .count    (instructionCount),
        .overflow (countOverflow)
    );

endmodule

// File: tb/tb_cpu_run_controller.sv
// Scoreboard bench for cpu_run_controller.
// Two instances: default config and a 4-bit free-running one.
module tb_cpu_run_controller;

    import cpu_ctrl_pkg::*;

    logic        clock = 1'b0;
    logic        isResetN;
    logic        runRequest;
    logic        haltRequest;
    logic        stepRequest;
    logic        haltInstruction;
    logic        breakEnable;
    logic [7:0]  breakAddress;
    logic [7:0]  pc;
    logic        cpuEnable;
    logic        cpuReset;
    logic        halted;
    logic        breakHit;
    logic        stepDone;
    logic [15:0] instructionCount;
    logic        countOverflow;

    logic        b_resetn;
    logic [7:0]  b_pc;
    logic        b_enable;
    logic        b_cpu_reset;
    logic        b_halted;
    logic        b_break_hit;
    logic        b_step_done;
    logic [3:0]  b_count;
    logic        b_overflow;

    always #5 clock = ~clock;

    cpu_run_controller dut (
        .clock            (clock),
        .isResetN         (isResetN),
        .runRequest       (runRequest),
        .haltRequest      (haltRequest),
        .stepRequest      (stepRequest),
        .haltInstruction  (haltInstruction),
        .breakEnable      (breakEnable),
        .breakAddress     (breakAddress),
        .pc               (pc),
        .cpuEnable        (cpuEnable),
        .cpuReset         (cpuReset),
        .halted           (halted),
        .breakHit         (breakHit),
        .stepDone         (stepDone),
        .instructionCount (instructionCount),
        .countOverflow    (countOverflow)
    );

    cpu_run_controller #(
        .COUNT_WIDTH  (4),
        .START_HALTED (1'b0)
    ) dut_wrap (
        .clock            (clock),
        .isResetN         (b_resetn),
        .runRequest       (1'b0),
        .haltRequest      (1'b0),
        .stepRequest      (1'b0),
        .haltInstruction  (1'b0),
        .breakEnable      (1'b0),
        .breakAddress     (8'h00),
        .pc               (b_pc),
        .cpuEnable        (b_enable),
        .cpuReset         (b_cpu_reset),
        .halted           (b_halted),
        .breakHit         (b_break_hit),
        .stepDone         (b_step_done),
        .instructionCount (b_count),
        .countOverflow    (b_overflow)
    );

    // CPU program counter stand-ins
    always @(posedge clock) begin
        if (!isResetN || cpuReset) pc <= 8'h00;
        else if (cpuEnable) pc <= pc + 8'h01;
    end

    always @(posedge clock) begin
        if (!b_resetn || b_cpu_reset) b_pc <= 8'h00;
        else if (b_enable) b_pc <= b_pc + 8'h01;
    end

    typedef enum int {
        S_EN, S_RST, S_HALT, S_BRK, S_SDONE, S_CNT, S_OVF, S_PC,
        S_BEN, S_BHALT, S_BRST, S_BCNT, S_BOVF
    } sig_e;

    typedef struct {
        int          cyc;
        sig_e        sig;
        logic [15:0] val;
        string       name;
    } exp_t;

    exp_t expq[$];
    exp_t cur;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [15:0] sample(input sig_e s);
        case (s)
            S_EN:    return {15'd0, cpuEnable};
            S_RST:   return {15'd0, cpuReset};
            S_HALT:  return {15'd0, halted};
            S_BRK:   return {15'd0, breakHit};
            S_SDONE: return {15'd0, stepDone};
            S_CNT:   return instructionCount;
            S_OVF:   return {15'd0, countOverflow};
            S_PC:    return {8'd0, pc};
            S_BEN:   return {15'd0, b_enable};
            S_BHALT: return {15'd0, b_halted};
            S_BRST:  return {15'd0, b_cpu_reset};
            S_BCNT:  return {12'd0, b_count};
            S_BOVF:  return {15'd0, b_overflow};
            default: return 16'hxxxx;
        endcase
    endfunction

    // Monitor: compare queued expectations mid-cycle
    always @(negedge clock) begin
        while (expq.size() > 0 && expq[0].cyc <= cyc) begin
            cur = expq.pop_front();
            n_checks++;
            if (sample(cur.sig) !== cur.val) begin
                n_fail++;
                $display("FAIL %s cyc=%0d got=%0h want=%0h",
                         cur.name, cyc, sample(cur.sig), cur.val);
            end
        end
    end

    task automatic want(input sig_e s, input logic [15:0] v,
                        input string n);
        exp_t e;
        e.cyc  = cyc;
        e.sig  = s;
        e.val  = v;
        e.name = n;
        expq.push_back(e);
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic clear_reqs();
        runRequest      = 1'b0;
        haltRequest     = 1'b0;
        stepRequest     = 1'b0;
        haltInstruction = 1'b0;
    endtask

    task automatic reset_a();
        isResetN = 1'b0;
        clear_reqs();
        repeat (3) tick();
        want(S_RST, 16'd1, "rst_hold_rst");
        want(S_HALT, 16'd0, "rst_hold_halted");
        want(S_EN, 16'd0, "rst_hold_en");
        want(S_CNT, 16'd0, "rst_hold_cnt");
        want(S_BRK, 16'd0, "rst_hold_brk");
        want(S_SDONE, 16'd0, "rst_hold_sdone");
        isResetN = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i < 3) begin
                want(S_RST, 16'd1, "rst_stretch");
                want(S_EN, 16'd0, "rst_stretch_en");
            end else begin
                want(S_RST, 16'd0, "rst_done");
                want(S_HALT, 16'd1, "rst_halted");
                want(S_EN, 16'd0, "rst_halted_en");
                want(S_CNT, 16'd0, "rst_cnt");
                want(S_OVF, 16'd0, "rst_ovf");
            end
        end
    endtask

    initial begin
        isResetN     = 1'b0;
        b_resetn     = 1'b0;
        breakEnable  = 1'b0;
        breakAddress = 8'h00;
        clear_reqs();

        reset_a();

        // single step
        stepRequest = 1'b1;
        tick();
        stepRequest = 1'b0;
        want(S_EN, 16'd1, "step_en");
        want(S_HALT, 16'd0, "step_running");
        want(S_SDONE, 16'd0, "step_sdone_early");
        tick();
        want(S_EN, 16'd0, "step_en_once");
        want(S_SDONE, 16'd1, "step_sdone");
        want(S_CNT, 16'd1, "step_cnt");
        want(S_HALT, 16'd1, "step_halted");
        tick();
        want(S_SDONE, 16'd0, "step_sdone_pulse");
        want(S_EN, 16'd0, "step_idle_en");

        // breakpoint from pc 0
        reset_a();
        breakAddress = 8'h05;
        breakEnable  = 1'b1;
        runRequest   = 1'b1;
        tick();
        runRequest = 1'b0;
        want(S_EN, 16'd1, "bp_run_pc0");
        for (int i = 1; i <= 5; i++) begin
            tick();
            if (i < 5) want(S_EN, 16'd1, "bp_run_en");
        end
        want(S_PC, 16'd5, "bp_pc");
        want(S_EN, 16'd0, "bp_trap_en");
        want(S_CNT, 16'd5, "bp_trap_cnt");
        tick();
        want(S_HALT, 16'd1, "bp_halted");
        want(S_BRK, 16'd1, "bp_hit");
        want(S_CNT, 16'd5, "bp_cnt");
        runRequest = 1'b1;
        tick();
        runRequest = 1'b0;
        want(S_EN, 16'd1, "bp_resume_en");
        want(S_BRK, 16'd0, "bp_resume_brk");
        want(S_PC, 16'd5, "bp_resume_pc");
        tick();
        want(S_PC, 16'd6, "bp_resume_pc6");
        want(S_CNT, 16'd6, "bp_resume_cnt");

        // halt opcode retires then halts
        haltInstruction = 1'b1;
        want(S_EN, 16'd1, "hinst_en");
        tick();
        haltInstruction = 1'b0;
        want(S_HALT, 16'd1, "hinst_halted");
        want(S_CNT, 16'd7, "hinst_cnt");
        want(S_EN, 16'd0, "hinst_stop_en");

        // all requests together in HALTED
        haltRequest = 1'b1;
        stepRequest = 1'b1;
        runRequest  = 1'b1;
        tick();
        clear_reqs();
        want(S_HALT, 16'd1, "coll_halted");
        want(S_EN, 16'd0, "coll_en");
        tick();
        want(S_HALT, 16'd1, "coll_halted2");
        want(S_CNT, 16'd7, "coll_cnt");

        // halt request colliding with breakpoint
        breakAddress = 8'h09;
        runRequest   = 1'b1;
        tick();
        runRequest = 1'b0;
        want(S_EN, 16'd1, "hbp_pc7");
        tick();
        want(S_EN, 16'd1, "hbp_pc8");
        tick();
        want(S_PC, 16'd9, "hbp_pc");
        haltRequest = 1'b1;
        want(S_EN, 16'd0, "hbp_no_retire");
        tick();
        haltRequest = 1'b0;
        want(S_HALT, 16'd1, "hbp_halted");
        want(S_BRK, 16'd1, "hbp_brk");
        want(S_CNT, 16'd9, "hbp_cnt");

        // reset in the middle of RUN
        breakEnable = 1'b0;
        runRequest  = 1'b1;
        tick();
        runRequest = 1'b0;
        want(S_EN, 16'd1, "mid_run_en");
        tick();
        want(S_CNT, 16'd10, "mid_run_cnt");
        isResetN = 1'b0;
        tick();
        want(S_RST, 16'd1, "mid_rst");
        want(S_CNT, 16'd0, "mid_rst_cnt");
        want(S_BRK, 16'd0, "mid_rst_brk");
        want(S_EN, 16'd0, "mid_rst_en");
        reset_a();

        // 4-bit counter wrap on free-running instance
        b_resetn = 1'b1;
        repeat (4) tick();
        want(S_BRST, 16'd0, "wrap_rst_done");
        want(S_BHALT, 16'd0, "wrap_runs");
        want(S_BEN, 16'd1, "wrap_en");
        want(S_BCNT, 16'd0, "wrap_cnt0");
        repeat (15) tick();
        want(S_BCNT, 16'd15, "wrap_cnt15");
        want(S_BOVF, 16'd0, "wrap_no_ovf");
        tick();
        want(S_BCNT, 16'd0, "wrap_cnt_zero");
        want(S_BOVF, 16'd1, "wrap_ovf");
        tick();
        want(S_BOVF, 16'd1, "wrap_ovf_sticky");

        for (int i = 0; i < 5 && expq.size() > 0; i++) tick();
        if (expq.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain pending=%0d want=0", expq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
